// File: rtl/rv64_alu_decode_pkg.sv
// Shared constants and decode helper for the RV64 ALU decode stage.
// Covers the add/sub/shift subset of OP, OP-32, OP-IMM and OP-IMM-32.
package rv64_alu_decode_pkg;

  // W variants sit on the odd encodings, one above their 64-bit twin.
  typedef enum logic [2:0] {
    AluAdd  = 3'd0,
    AluAddw = 3'd1,
    AluSub  = 3'd2,
    AluSubw = 3'd3,
    AluSll  = 3'd4,
    AluSllw = 3'd5,
    AluSra  = 3'd6,
    AluSraw = 3'd7
  } alu_op_e;

  localparam logic [6:0] OpcOp      = 7'b0110011;
  localparam logic [6:0] OpcOp32    = 7'b0111011;
  localparam logic [6:0] OpcOpImm   = 7'b0010011;
  localparam logic [6:0] OpcOpImm32 = 7'b0011011;

  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Sra    = 3'b101;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  typedef struct packed {
    logic        legal;
    logic        use_rs2;
    alu_op_e     op;
    logic [63:0] imm;
  } dec_t;

  function automatic dec_t decode_inst(logic [31:0] inst);
    dec_t       d;
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    opc       = inst[6:0];
    f3        = inst[14:12];
    f7        = inst[31:25];
    d.legal   = 1'b0;
    d.use_rs2 = 1'b0;
    d.op      = AluAdd;
    d.imm     = '0;
    case (opc)
      OpcOp, OpcOp32: begin
        d.use_rs2 = 1'b1;
        d.legal   = 1'b1;
        if (f3 == F3AddSub && f7 == F7Base) d.op = AluAdd;
        else if (f3 == F3AddSub && f7 == F7Alt) d.op = AluSub;
        else if (f3 == F3Sll && f7 == F7Base) d.op = AluSll;
        else if (f3 == F3Sra && f7 == F7Alt) d.op = AluSra;
        else d.legal = 1'b0;
      end
      OpcOpImm: begin
        if (f3 == F3AddSub) begin
          d.legal = 1'b1;
          d.op    = AluAdd;
          d.imm   = {{52{inst[31]}}, inst[31:20]};
        end else if (f3 == F3Sll && inst[31:26] == F7Base[6:1]) begin
          d.legal = 1'b1;
          d.op    = AluSll;
          d.imm   = {58'd0, inst[25:20]};
        end else if (f3 == F3Sra && inst[31:26] == F7Alt[6:1]) begin
          d.legal = 1'b1;
          d.op    = AluSra;
          d.imm   = {58'd0, inst[25:20]};
        end
      end
      OpcOpImm32: begin
        if (f3 == F3AddSub) begin
          d.legal = 1'b1;
          d.op    = AluAdd;
          d.imm   = {{52{inst[31]}}, inst[31:20]};
        end else if (f3 == F3Sll && f7 == F7Base) begin
          d.legal = 1'b1;
          d.op    = AluSll;
          d.imm   = {59'd0, inst[24:20]};
        end else if (f3 == F3Sra && f7 == F7Alt) begin
          d.legal = 1'b1;
          d.op    = AluSra;
          d.imm   = {59'd0, inst[24:20]};
        end
      end
      default: ;
    endcase
    if (opc == OpcOp32 || opc == OpcOpImm32) d.op = alu_op_e'(d.op | 3'd1);
    return d;
  endfunction

endpackage

// File: rtl/rv64_regfile.sv
// 32x64 integer register file: two combinational read ports, one write port, x0 hardwired to zero.
module rv64_regfile (
  input  logic        clk_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [63:0] rdata1_o,
  output logic [63:0] rdata2_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [63:0] wdata_i
);

  logic [63:0] mem_q [32];

  always_ff @(posedge clk_i) begin
    if (we_i && waddr_i != 5'd0) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? 64'd0 : mem_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? 64'd0 : mem_q[raddr2_i];

endmodule

// File: rtl/rv64_alu_decode.sv
// RV64 add/sub/shift decode stage with scoreboard stall, writeback bypass and a single
// registered ALU operand stage; undecodable instructions are dropped and counted.
module rv64_alu_decode
  import rv64_alu_decode_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid,
  output logic             inst_ready,
  input  logic [31:0]      inst,
  output logic             alu_valid,
  input  logic             alu_ready,
  output logic [63:0]      alu_a,
  output logic [63:0]      alu_b,
  output logic [2:0]       alu_op,
  output logic [4:0]       alu_rd,
  input  logic             wb_en,
  input  logic [4:0]       wb_rd,
  input  logic [63:0]      wb_data,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  dec_t        dec;
  logic [4:0]  rs1, rs2, rd;
  logic [63:0] rf_rdata1, rf_rdata2, src1, src2;
  logic        rs1_busy, rs2_busy, stall, accept, issue;

  logic             alu_valid_q, alu_valid_d;
  logic [63:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  alu_op_e          alu_op_q, alu_op_d;
  logic [4:0]       alu_rd_q, alu_rd_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] illegal_count_q, illegal_count_d;
  logic [31:0]      pending_q, pending_d;

  assign dec = decode_inst(inst);
  assign rs1 = inst[19:15];
  assign rs2 = inst[24:20];
  assign rd  = inst[11:7];

  rv64_regfile u_regfile (
    .clk_i    (clk),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rf_rdata1),
    .rdata2_o (rf_rdata2),
    .we_i     (wb_en),
    .waddr_i  (wb_rd),
    .wdata_i  (wb_data)
  );

  // A writeback landing this cycle both forwards its data and releases the pending bit.
  assign src1 = (wb_en && wb_rd != 5'd0 && wb_rd == rs1) ? wb_data : rf_rdata1;
  assign src2 = (wb_en && wb_rd != 5'd0 && wb_rd == rs2) ? wb_data : rf_rdata2;

  assign rs1_busy = pending_q[rs1] && !(wb_en && wb_rd == rs1);
  assign rs2_busy = pending_q[rs2] && !(wb_en && wb_rd == rs2);
  assign stall    = dec.legal && (rs1_busy || (dec.use_rs2 && rs2_busy));

  assign inst_ready = (!alu_valid_q || alu_ready) && !stall;
  assign accept     = inst_valid && inst_ready;
  assign issue      = accept && dec.legal;

  always_comb begin
    alu_valid_d     = alu_valid_q;
    alu_a_d         = alu_a_q;
    alu_b_d         = alu_b_q;
    alu_op_d        = alu_op_q;
    alu_rd_d        = alu_rd_q;
    illegal_d       = accept && !dec.legal;
    illegal_count_d = illegal_count_q;
    pending_d       = pending_q;

    if (issue) begin
      alu_valid_d = 1'b1;
      alu_a_d     = src1;
      alu_b_d     = dec.use_rs2 ? src2 : dec.imm;
      alu_op_d    = dec.op;
      alu_rd_d    = rd;
    end else if (alu_ready) begin
      alu_valid_d = 1'b0;
    end

    if (illegal_d && illegal_count_q != {CNT_W{1'b1}}) begin
      illegal_count_d = illegal_count_q + CNT_W'(1);
    end

    // Clear before set so a same-cycle issue to the same rd keeps the bit pending.
    if (wb_en) pending_d[wb_rd] = 1'b0;
    if (issue && rd != 5'd0) pending_d[rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_valid_q     <= 1'b0;
      alu_a_q         <= '0;
      alu_b_q         <= '0;
      alu_op_q        <= AluAdd;
      alu_rd_q        <= '0;
      illegal_q       <= 1'b0;
      illegal_count_q <= '0;
      pending_q       <= '0;
    end else begin
      alu_valid_q     <= alu_valid_d;
      alu_a_q         <= alu_a_d;
      alu_b_q         <= alu_b_d;
      alu_op_q        <= alu_op_d;
      alu_rd_q        <= alu_rd_d;
      illegal_q       <= illegal_d;
      illegal_count_q <= illegal_count_d;
      pending_q       <= pending_d;
    end
  end

  assign alu_valid     = alu_valid_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_op        = alu_op_q;
  assign alu_rd        = alu_rd_q;
  assign illegal       = illegal_q;
  assign illegal_count = illegal_count_q;

endmodule

// File: tb/tb_rv64_alu_decode.sv
// Bench for rv64_alu_decode: directed scenarios with literal expectations, then random traffic,
// all continuously compared against an instruction-level reference model.
module tb_rv64_alu_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic [31:0] inst = 32'd0;
  logic        alu_valid;
  logic        alu_ready = 1'b0;
  logic [63:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [4:0]  alu_rd;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic [63:0] wb_data = 64'd0;
  logic        illegal;
  logic [15:0] illegal_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  rv64_alu_decode #(.CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_op        (alu_op),
    .alu_rd        (alu_rd),
    .wb_en         (wb_en),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .illegal       (illegal),
    .illegal_count (illegal_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [63:0] x [32];
  bit          pend [32];
  bit          m_valid = 1'b0;
  bit          m_ill = 1'b0;
  logic [15:0] m_cnt = 16'd0;
  logic [63:0] m_a = 64'd0, m_b = 64'd0;
  logic [2:0]  m_op = 3'd0;
  logic [4:0]  m_rd = 5'd0;

  function automatic void mdecode(input logic [31:0] i, output bit lg, output logic [2:0] op,
                                  output bit u2, output logic [63:0] imm);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    bit w;
    opc = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    lg = 0; op = 0; u2 = 0; imm = 0;
    w = (opc == 7'b0111011) || (opc == 7'b0011011);
    if (opc == 7'b0110011 || opc == 7'b0111011) begin
      u2 = 1;
      if (f3 == 0 && f7 == 7'h00) begin lg = 1; op = 0; end
      else if (f3 == 0 && f7 == 7'h20) begin lg = 1; op = 2; end
      else if (f3 == 1 && f7 == 7'h00) begin lg = 1; op = 4; end
      else if (f3 == 5 && f7 == 7'h20) begin lg = 1; op = 6; end
    end else if (opc == 7'b0010011) begin
      if (f3 == 0) begin lg = 1; op = 0; imm = {{52{i[31]}}, i[31:20]}; end
      else if (f3 == 1 && i[31:26] == 6'h00) begin lg = 1; op = 4; imm = {58'd0, i[25:20]}; end
      else if (f3 == 5 && i[31:26] == 6'h10) begin lg = 1; op = 6; imm = {58'd0, i[25:20]}; end
    end else if (opc == 7'b0011011) begin
      if (f3 == 0) begin lg = 1; op = 0; imm = {{52{i[31]}}, i[31:20]}; end
      else if (f3 == 1 && f7 == 7'h00) begin lg = 1; op = 4; imm = {59'd0, i[24:20]}; end
      else if (f3 == 5 && f7 == 7'h20) begin lg = 1; op = 6; imm = {59'd0, i[24:20]}; end
    end
    if (lg && w) op = op + 3'd1;
  endfunction

  function automatic logic [63:0] mread(input logic [4:0] r);
    if (r == 0) return 64'd0;
    if (wb_en && wb_rd == r) return wb_data;
    return x[r];
  endfunction

  function automatic bit m_ready();
    bit lg, u2, busy1, busy2;
    logic [2:0] op;
    logic [63:0] imm;
    mdecode(inst, lg, op, u2, imm);
    busy1 = pend[inst[19:15]] && !(wb_en && wb_rd == inst[19:15]);
    busy2 = pend[inst[24:20]] && !(wb_en && wb_rd == inst[24:20]);
    return (!m_valid || alu_ready) && !(lg && (busy1 || (u2 && busy2)));
  endfunction

  always @(posedge clk) begin
    bit lg, u2, acc;
    logic [2:0] op;
    logic [63:0] imm;
    mdecode(inst, lg, op, u2, imm);
    if (rst) begin
      m_valid = 0; m_ill = 0; m_cnt = 0; m_a = 0; m_b = 0; m_op = 0; m_rd = 0;
      for (int r = 0; r < 32; r++) pend[r] = 0;
    end else begin
      acc = inst_valid && m_ready();
      m_ill = acc && !lg;
      if (m_ill && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (acc && lg) begin
        m_valid = 1;
        m_a     = mread(inst[19:15]);
        m_b     = u2 ? mread(inst[24:20]) : imm;
        m_op    = op;
        m_rd    = inst[11:7];
      end else if (alu_ready) begin
        m_valid = 0;
      end
      if (wb_en) pend[wb_rd] = 0;
      if (acc && lg && inst[11:7] != 0) pend[inst[11:7]] = 1;
    end
    if (wb_en && wb_rd != 0) x[wb_rd] = wb_data;
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m_inst_ready", 64'(inst_ready), 64'(m_ready()));
      cmp("m_alu_valid", 64'(alu_valid), 64'(m_valid));
      cmp("m_illegal", 64'(illegal), 64'(m_ill));
      cmp("m_illegal_count", 64'(illegal_count), 64'(m_cnt));
      if (m_valid) begin
        cmp("m_alu_a", alu_a, m_a);
        cmp("m_alu_b", alu_b, m_b);
        cmp("m_alu_op", 64'(alu_op), 64'(m_op));
        cmp("m_alu_rd", 64'(alu_rd), 64'(m_rd));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {f7, r2, r1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int kind, cls;
    w = $urandom;
    if ($urandom_range(0, 9) < 3) return w;
    kind = $urandom_range(0, 3);
    cls  = $urandom_range(0, 3);
    w[19:15] = 5'($urandom_range(0, 7));
    w[11:7]  = 5'($urandom_range(0, 7));
    case (cls)
      0: w[6:0] = 7'b0110011;
      1: w[6:0] = 7'b0111011;
      2: w[6:0] = 7'b0010011;
      default: w[6:0] = 7'b0011011;
    endcase
    if (cls < 2) begin
      w[24:20] = 5'($urandom_range(0, 7));
      w[31:25] = (kind == 1 || kind == 3) ? 7'h20 : 7'h00;
      w[14:12] = (kind < 2) ? 3'd0 : (kind == 2) ? 3'd1 : 3'd5;
    end else if (kind < 2) begin
      w[14:12] = 3'd0;
    end else begin
      w[14:12] = (kind == 2) ? 3'd1 : 3'd5;
      w[31:26] = (kind == 2) ? 6'h00 : 6'h10;
      if (cls == 3) w[25] = 1'b0;
    end
    if ($urandom_range(0, 9) == 0) w[25] = ~w[25];
    return w;
  endfunction

  initial begin
    for (int r = 0; r < 32; r++) pend[r] = 0;
    repeat (2) cyc();
    chk_en = 1'b1;
    cmp("rst_alu_valid", 64'(alu_valid), 64'd0);
    cmp("rst_illegal", 64'(illegal), 64'd0);
    cmp("rst_count", 64'(illegal_count), 64'd0);
    cmp("rst_alu_a", alu_a, 64'd0);
    cmp("rst_alu_rd_op", 64'({alu_rd, alu_op}), 64'd0);
    rst = 1'b0;

    // ADD x3,x1,x2 with x1=5, x2=3
    wb_en = 1; wb_rd = 1; wb_data = 64'd5; cyc();
    wb_rd = 2; wb_data = 64'd3; cyc();
    wb_en = 0; alu_ready = 1; inst_valid = 1;
    inst = rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011);
    cyc();
    cmp("add_valid", 64'(alu_valid), 64'd1);
    cmp("add_op", 64'(alu_op), 64'd0);
    cmp("add_a", alu_a, 64'd5);
    cmp("add_b", alu_b, 64'd3);
    cmp("add_rd", 64'(alu_rd), 64'd3);

    // SUB x5,x3,x1 stalls on x3 until its writeback, then takes the bypassed value
    inst = rtype(7'h20, 5'd1, 5'd3, 3'd0, 5'd5, 7'b0110011);
    @(negedge clk); cmp("raw_stall0", 64'(inst_ready), 64'd0);
    cyc();
    @(negedge clk); cmp("raw_stall1", 64'(inst_ready), 64'd0);
    cyc();
    wb_en = 1; wb_rd = 3; wb_data = 64'h1234;
    @(negedge clk); cmp("raw_release", 64'(inst_ready), 64'd1);
    cyc();
    wb_en = 0;
    cmp("sub_op", 64'(alu_op), 64'd2);
    cmp("sub_a", alu_a, 64'h1234);
    cmp("sub_b", alu_b, 64'd5);
    cmp("sub_rd", 64'(alu_rd), 64'd5);

    // ADDIW x4,x0,-1 then SRAIW x6,x1,31
    inst = {12'hFFF, 5'd0, 3'd0, 5'd4, 7'b0011011};
    cyc();
    cmp("addiw_op", 64'(alu_op), 64'd1);
    cmp("addiw_a", alu_a, 64'd0);
    cmp("addiw_b", alu_b, 64'hFFFF_FFFF_FFFF_FFFF);
    inst = {7'b0100000, 5'd31, 5'd1, 3'd5, 5'd6, 7'b0011011};
    cyc();
    cmp("sraiw_op", 64'(alu_op), 64'd7);
    cmp("sraiw_b", alu_b, 64'd31);

    // Backpressure: hold ADD x7 for three cycles, then let ADD x8 follow
    inst_valid = 0; cyc();
    inst_valid = 1; alu_ready = 0;
    inst = rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd7, 7'b0110011);
    cyc();
    inst = rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd8, 7'b0110011);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); cmp("bp_ready", 64'(inst_ready), 64'd0);
      cyc();
      cmp("bp_hold", {alu_a[31:0], 27'd0, alu_rd}, {32'd5, 27'd0, 5'd7});
      cmp("bp_valid", 64'(alu_valid), 64'd1);
    end
    alu_ready = 1;
    @(negedge clk); cmp("bp_release", 64'(inst_ready), 64'd1);
    cyc();
    cmp("bp_next_rd", 64'(alu_rd), 64'd8);

    // Illegal word
    inst = 32'hFFFF_FFFF;
    cyc();
    cmp("ill_pulse", 64'(illegal), 64'd1);
    cmp("ill_valid", 64'(alu_valid), 64'd0);
    cmp("ill_count", 64'(illegal_count), 64'd1);
    inst_valid = 0; cyc();
    cmp("ill_pulse_end", 64'(illegal), 64'd0);

    // Reset mid-operation: held ADD x3 dropped, stalled SUB x10,x3,x1 then accepted
    inst_valid = 1; alu_ready = 0;
    inst = rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011);
    cyc();
    inst = rtype(7'h20, 5'd1, 5'd3, 3'd0, 5'd10, 7'b0110011);
    @(negedge clk); cmp("pre_rst_ready", 64'(inst_ready), 64'd0);
    rst = 1; cyc();
    cmp("mid_rst_valid", 64'(alu_valid), 64'd0);
    cmp("mid_rst_count", 64'(illegal_count), 64'd0);
    rst = 0;
    @(negedge clk); cmp("post_rst_ready", 64'(inst_ready), 64'd1);
    cyc();
    cmp("post_rst_rd", 64'(alu_rd), 64'd10);
    cmp("post_rst_a", alu_a, 64'h1234);

    // Fill the register file so random traffic never reads unwritten entries
    inst_valid = 0; alu_ready = 1;
    for (int r = 1; r < 32; r++) begin
      wb_en = 1; wb_rd = 5'(r); wb_data = {$urandom, $urandom}; cyc();
    end
    wb_en = 0;

    // Counter saturation
    inst_valid = 1; inst = 32'hFFFF_FFFF;
    repeat (65535) cyc();
    cmp("sat_reach", 64'(illegal_count), 64'hFFFF);
    cyc();
    cmp("sat_hold", 64'(illegal_count), 64'hFFFF);
    cmp("sat_pulse", 64'(illegal), 64'd1);
    inst_valid = 0; rst = 1; cyc(); rst = 0;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 299) == 0);
      inst_valid = ($urandom_range(0, 3) != 0);
      inst       = rand_inst();
      alu_ready  = ($urandom_range(0, 9) < 7);
      wb_en      = ($urandom_range(0, 9) < 4);
      wb_rd      = 5'($urandom_range(0, 7));
      wb_data    = {$urandom, $urandom};
      cyc();
    end
    rst = 0; inst_valid = 0; wb_en = 0;
    cyc();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv64_alu_decode.md
RV64_ALU_DECODE -- requirements
Module: rv64_alu_decode

Interface
REQ-001 Parameter: CNT_W, 16, width of illegal-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 inst_valid  input  1  upstream instruction valid.
REQ-005 inst_ready  output  1  decoder can accept instruction this cycle.
REQ-006 inst  input  32  RV64 instruction word.
REQ-007 alu_valid  output  1  registered ALU operands valid.
REQ-008 alu_ready  input  1  ALU stage consumes operands this cycle.
REQ-009 alu_a, alu_b  output  64 each  ALU operands.
REQ-010 alu_op  output  3  ALU opcode: ADD=0, ADDW=1, SUB=2, SUBW=3, SLL=4, SLLW=5, SRA=6, SRAW=7.
REQ-011 alu_rd  output  5  destination register of issued op.
REQ-012 wb_en, wb_rd, wb_data  input  1/5/64  writeback from downstream stage.
REQ-013 illegal  output  1  one-cycle pulse when an undecodable instruction is dropped.
REQ-014 illegal_count  output  CNT_W  saturating count of dropped instructions.

Function
REQ-015 Decode: opcode 0110011 -> ADD (f3=000,f7=0000000), SUB (000,0100000), SLL (001,0000000), SRA (101,0100000); opcode 0111011 -> ADDW/SUBW/SLLW/SRAW, same f3/f7.
REQ-016 Decode immediates: 0010011 ADDI->ADD, SLLI (f3=001, inst[31:26]=0)->SLL, SRAI (f3=101, inst[31:26]=010000)->SRA; 0011011 ADDIW->ADDW, SLLIW (inst[31:25]=0)->SLLW, SRAIW (inst[31:25]=0100000)->SRAW.
REQ-017 Immediate operand: ADDI/ADDIW alu_b = sign-extended inst[31:20] to 64 bits; shift-immediates alu_b = zero-extended shamt (inst[25:20], or inst[24:20] for W forms).
REQ-018 Register operands: alu_a = x[rs1]; alu_b = x[rs2] for R-type.
REQ-019 All other encodings are illegal: accepted, dropped, no ALU issue, illegal pulses in the cycle after acceptance.
REQ-020 Internal 32x64 register file; x0 reads zero; writes with wb_rd=0 ignored.
REQ-021 Write-through bypass: if wb_en and wb_rd equals nonzero rs in the accept cycle, operand takes wb_data.
REQ-022 Scoreboard: 32 pending bits; set for rd!=0 when a legal instruction is accepted; cleared when wb_en with matching wb_rd.
REQ-023 Same-cycle set and clear of one register: set wins.
REQ-024 Stall: legal instruction whose used rs1/rs2 is pending and not cleared this cycle is not accepted.
REQ-025 inst_ready = (!alu_valid || alu_ready) && !stall; illegal instructions ignore the scoreboard term.
REQ-026 Latency: accepted legal instruction appears on alu_* exactly one cycle later; output register holds stable while alu_valid && !alu_ready.
REQ-027 Back-to-back issue at one per cycle when no stall and alu_ready held high.
REQ-028 illegal_count increments per illegal acceptance, saturates at all-ones.

Reset
REQ-029 On rst: alu_valid=0, illegal=0, illegal_count=0, all scoreboard bits 0, alu_a/alu_b/alu_rd/alu_op=0.
REQ-030 Register file contents are not reset; reset mid-operation discards the held output operation.

Structure
REQ-031 Shared package holds ALU opcode constants (0-7) and RV64 opcode/funct constants.
REQ-032 One sub-module rv64_regfile: 32x64, two combinational read ports, one write port, x0 zero.
REQ-033 Decode logic is combinational; the only pipeline register is the alu_* output stage.

Verification
REQ-034 rst, wb x1=5, x2=3; inst ADD x3,x1,x2 -> next cycle alu_valid=1, op=0, a=5, b=3, rd=3.
REQ-035 ADDIW x4,x0,-1 -> op=1, a=0, b=0xFFFF_FFFF_FFFF_FFFF; SRAIW shamt 31 -> op=7, b=31.
REQ-036 ADD x3,.. then SUB x5,x3,x1 immediately -> inst_ready=0 until wb_en rd=3; SUB accepted in the wb cycle with a=wb_data.
REQ-037 alu_ready=0 for 3 cycles with alu_valid=1 -> alu_* unchanged, inst_ready=0; release -> next issue follows.
REQ-038 inst=0xFFFF_FFFF -> illegal pulse one cycle, alu_valid stays 0, illegal_count=1; preset counter 0xFFFF plus one illegal -> stays 0xFFFF.
REQ-039 Assert rst while alu_valid=1 and pending bits set -> next cycle alu_valid=0, previously stalled instruction accepted.
